alu_ctrl_stage: RTL and testbench
=================================

# alu_ctrl_stage

Decode-to-execute issue stage for the RV32I datapath. Accepts one instruction plus its register operands per handshake, decodes opcode/funct3/funct7 into the 4-bit ALU `Operation` code and builds `SrcA`/`SrcB`, and holds the result in a 2-entry skid buffer. It drives the ALU's operand and operation inputs with a registered output. It sits between register-file read and the ALU, and absorbs execute-side stalls without a combinational ready path back to decode.

## Interface
- `DATA_WIDTH`, 32, operand/immediate width.
- `OPCODE_LENGTH`, 4, ALU operation code width.
- `clk  input  1`: single clock; all state updates on rising edge.
- `reset  input  1`: synchronous, active-high.
- `in_valid  input  1`: upstream offers an instruction.
- `in_ready  output  1`: stage can accept; registered, not a function of `out_ready`.
- `in_instr  input  32`: instruction word.
- `in_rs1  input  DATA_WIDTH`: rs1 read data.
- `in_rs2  input  DATA_WIDTH`: rs2 read data.
- `out_valid  output  1`: decoded entry available.
- `out_ready  input  1`: execute side accepts.
- `SrcA  output  DATA_WIDTH`: ALU operand A.
- `SrcB  output  DATA_WIDTH`: ALU operand B.
- `Operation  output  OPCODE_LENGTH`: ALU operation code.
- `out_illegal  output  1`: entry decoded as unsupported.
- `illegal_count  output  16`: saturating illegal-instruction count (macro-gated; see Configuration).

## Operation
- Operation codes: AND 0000, XOR 0001, SUB 0010, OR 0011, ADD 0100, BGE 0101, BNE 0110, SRAI 0111, BEQ 1000, SLL 1001, LUI 1010, SRL 1100, BLT 1101, SLT 1110.
- The immediate is sign-extended from instr[31:20] for I-type loads and JALR, and from {instr[31:25],instr[11:7]} for stores.
- Decode:
  - R-type 0110011:
    - funct3 000 with funct7 0000000 → ADD; funct7 0100000 → SUB.
    - funct3 100 → XOR; 110 → OR; 111 → AND; 010 → SLT (funct7 must be 0).
    - SrcA=rs1, SrcB=rs2.
  - I-type 0010011:
    - funct3 000 → ADD; 010 → SLT; 100 → XOR; 110 → OR; 111 → AND.
    - funct3 001 with funct7 0 → SLL.
    - funct3 101 with funct7 0 → SRL; funct7 0100000 → SRAI.
    - SrcA=rs1, SrcB=sign-extended imm. For SRAI, SrcB = imm = 1024+shamt; the ALU removes the 1024 bias.
  - Load 0000011, store 0100011, JALR 1100111: ADD, SrcA=rs1, SrcB=imm.
  - Branch 1100011:
    - funct3 000 → BEQ; 001 → BNE; 100 → BLT; 101 → BGE.
    - SrcA=rs1, SrcB=rs2.
  - LUI 0110111: LUI, SrcA=0, SrcB={instr[31:12],12'b0}.
  - Anything else, including unlisted funct3/funct7 combinations, is illegal: Operation=0000, SrcA=SrcB=0, out_illegal=1. The entry still flows through the buffer.
- Skid buffer: 2 entries, FIFO order. Occupancy is 0, 1 or 2.
  - Push when in_valid&&in_ready.
  - Pop when out_valid&&out_ready.
  - in_ready = (occupancy<2), registered.
  - Head entry drives the outputs.

## Timing
- Reset values: out_valid=0, in_ready=1, SrcA=SrcB=0, Operation=0000, out_illegal=0, illegal_count=0, occupancy=0. In-flight entries are discarded.
- Latency: an instruction accepted at edge N is visible with out_valid=1 after edge N (1 cycle).
- Throughput: 1 instruction/cycle when out_ready is held high.
- Outputs are stable while out_valid&&!out_ready.
- Simultaneous push and pop: at occupancy 1, it stays 1 and the new entry becomes head. At occupancy 2, no push occurs (in_ready=0); the pop drops occupancy to 1, and in_ready=1 next cycle.
- Empty: out_valid=0; SrcA/SrcB/Operation hold their last values.
- reset asserted concurrently with in_valid: the input is dropped.

## Configuration
- `ALU_CTRL_ILLEGAL_CNT_EN` defined: illegal_count increments by 1 on each pop of an entry with out_illegal=1, saturating at 16'hFFFF.
- Macro undefined: illegal_count is tied to 0 and no counter logic is generated.

## Test plan
- Reset, then push `add x3,x1,x2` with rs1=5, rs2=7 → one cycle later out_valid=1, Operation=0100, SrcA=5, SrcB=7.
- Push `srai x1,x2,3` (0x40315093) with rs1=0xFFFFFF00 → Operation=0111, SrcB=1027.
- Push `lui x5,0x12345` → Operation=1010, SrcA=0, SrcB=0x12345000. Push `bge` → Operation=0101.
- Hold out_ready=0 and push 3 instructions back-to-back:
  - in_ready drops after the 2nd push; the 3rd is held.
  - Raise out_ready: outputs appear in order, with no loss or duplication.
- Push opcode 0x7F, then pop → out_illegal=1, Operation=0000. With the macro defined, illegal_count=1; without it, illegal_count=0.
- Fill the buffer to 2, assert reset for one cycle → out_valid=0, in_ready=1, and no stale entry appears afterward.

Source files
------------

// File: rtl/alu_ctrl_stage_if.sv
// alu_ctrl_stage_if: handshake and operand bus of the decode-to-execute issue stage.
//   Upstream side : in_valid, in_ready, in_instr, in_rs1, in_rs2
//   Execute side  : out_valid, out_ready, SrcA, SrcB, Operation, out_illegal
//   Status        : illegal_count (saturating illegal-instruction count)
//   modport master : the environment (decode and execute side)
//   modport slave  : the issue stage itself
interface alu_ctrl_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic [DATA_WIDTH-1:0]    in_rs1;
  logic [DATA_WIDTH-1:0]    in_rs2;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     out_illegal;
  logic [15:0]              illegal_count;

  modport master (
    output in_valid, in_instr, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, SrcA, SrcB, Operation, out_illegal, illegal_count
  );

  modport slave (
    input  in_valid, in_instr, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, SrcA, SrcB, Operation, out_illegal, illegal_count
  );
endinterface

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: RV32I decode-to-execute issue stage.
// Decodes opcode/funct3/funct7 into the 4-bit ALU operation code, builds
// SrcA/SrcB, and queues the result in a 2-entry skid buffer whose head
// drives registered ALU inputs. in_ready is registered (occupancy < 2), so
// there is no combinational path from out_ready back to decode.
// Ports:
//   clk   : clock, all state updates on rising edge
//   reset : synchronous, active-high; discards in-flight entries
//   bus   : alu_ctrl_stage_if.slave (handshakes, operands, Operation,
//           out_illegal, illegal_count)
// Optional feature: define ALU_CTRL_ILLEGAL_CNT_EN to enable the saturating
// illegal_count (increments per popped illegal entry); otherwise it is 0.
module alu_ctrl_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  alu_ctrl_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_XOR  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_ADD  = 4'b0100,
    OP_BGE  = 4'b0101,
    OP_BNE  = 4'b0110,
    OP_SRAI = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_SLL  = 4'b1001,
    OP_LUI  = 4'b1010,
    OP_SRL  = 4'b1100,
    OP_BLT  = 4'b1101,
    OP_SLT  = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    alu_op_e               op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  ill;
  } entry_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;
  logic                  legal;
  entry_t                dec;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];
  assign imm_i  = DATA_WIDTH'($signed(bus.in_instr[31:20]));
  assign imm_s  = DATA_WIDTH'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
  assign imm_u  = DATA_WIDTH'({bus.in_instr[31:12], 12'b0});

  always_comb begin
    dec.op  = OP_AND;
    dec.a   = bus.in_rs1;
    dec.b   = bus.in_rs2;
    dec.ill = 1'b0;
    legal   = 1'b0;

    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000: begin
            if (funct7 == F7_ZERO) begin
              dec.op = OP_ADD;
              legal  = 1'b1;
            end else if (funct7 == F7_ALT) begin
              dec.op = OP_SUB;
              legal  = 1'b1;
            end
          end
          3'b100:  begin dec.op = OP_XOR; legal = (funct7 == F7_ZERO); end
          3'b110:  begin dec.op = OP_OR;  legal = (funct7 == F7_ZERO); end
          3'b111:  begin dec.op = OP_AND; legal = (funct7 == F7_ZERO); end
          3'b010:  begin dec.op = OP_SLT; legal = (funct7 == F7_ZERO); end
          default: legal = 1'b0;
        endcase
      end

      OPC_I: begin
        dec.b = imm_i;
        case (funct3)
          3'b000: begin dec.op = OP_ADD; legal = 1'b1; end
          3'b010: begin dec.op = OP_SLT; legal = 1'b1; end
          3'b100: begin dec.op = OP_XOR; legal = 1'b1; end
          3'b110: begin dec.op = OP_OR;  legal = 1'b1; end
          3'b111: begin dec.op = OP_AND; legal = 1'b1; end
          3'b001: begin dec.op = OP_SLL; legal = (funct7 == F7_ZERO); end
          3'b101: begin
            // SRAI keeps the full imm (1024 + shamt); the ALU strips the bias.
            if (funct7 == F7_ZERO) begin
              dec.op = OP_SRL;
              legal  = 1'b1;
            end else if (funct7 == F7_ALT) begin
              dec.op = OP_SRAI;
              legal  = 1'b1;
            end
          end
          default: legal = 1'b0;
        endcase
      end

      OPC_LOAD, OPC_JALR: begin
        dec.op = OP_ADD;
        dec.b  = imm_i;
        legal  = 1'b1;
      end

      OPC_STORE: begin
        dec.op = OP_ADD;
        dec.b  = imm_s;
        legal  = 1'b1;
      end

      OPC_BRANCH: begin
        case (funct3)
          3'b000:  begin dec.op = OP_BEQ; legal = 1'b1; end
          3'b001:  begin dec.op = OP_BNE; legal = 1'b1; end
          3'b100:  begin dec.op = OP_BLT; legal = 1'b1; end
          3'b101:  begin dec.op = OP_BGE; legal = 1'b1; end
          default: legal = 1'b0;
        endcase
      end

      OPC_LUI: begin
        dec.op = OP_LUI;
        dec.a  = '0;
        dec.b  = imm_u;
        legal  = 1'b1;
      end

      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.op  = OP_AND;
      dec.a   = '0;
      dec.b   = '0;
      dec.ill = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // 2-entry skid buffer: head is the registered output, skid holds the
  // second entry while the execute side stalls.
  // ---------------------------------------------------------------------
  occ_e   occ;
  entry_t head;
  entry_t skid;
  logic   in_ready_r;
  logic   out_valid_r;
  logic   push;
  logic   pop;

  assign push = bus.in_valid && in_ready_r;
  assign pop  = out_valid_r && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ         <= OCC_EMPTY;
      head        <= '0;
      skid        <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head        <= dec;
            occ         <= OCC_ONE;
            out_valid_r <= 1'b1;
          end
        end

        OCC_ONE: begin
          if (push && pop) begin
            head <= dec;
          end else if (push) begin
            skid       <= dec;
            occ        <= OCC_FULL;
            in_ready_r <= 1'b0;
          end else if (pop) begin
            // Head fields are left as-is so the ALU inputs hold when empty.
            occ         <= OCC_EMPTY;
            out_valid_r <= 1'b0;
          end
        end

        OCC_FULL: begin
          if (pop) begin
            head       <= skid;
            occ        <= OCC_ONE;
            in_ready_r <= 1'b1;
          end
        end

        default: begin
          occ         <= OCC_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.SrcA        = head.a;
  assign bus.SrcB        = head.b;
  assign bus.Operation   = OPCODE_LENGTH'(head.op);
  assign bus.out_illegal = head.ill;

  // ---------------------------------------------------------------------
  // Illegal-instruction counter
  // ---------------------------------------------------------------------
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [15:0] ill_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ill_cnt <= '0;
    end else if (pop && head.ill && (ill_cnt != '1)) begin
      ill_cnt <= ill_cnt + 16'd1;
    end
  end

  assign bus.illegal_count = ill_cnt;
`else
  assign bus.illegal_count = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
module tb_alu_ctrl_stage;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  alu_ctrl_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_ctrl_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  exp_t        cur_exp;
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n_push = 0;
  int unsigned n_pop  = 0;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  localparam logic [15:0] CNT_STEP = 16'd1;
`else
  localparam logic [15:0] CNT_STEP = 16'd0;
`endif

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic ill);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.ill = ill;
    return e;
  endfunction

  // Scoreboard: pop/compare on each handshake-out, push on each handshake-in.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        total++;
        n_pop++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got op=%h a=%h b=%h ill=%b, expected no output",
                   bus.Operation, bus.SrcA, bus.SrcB, bus.out_illegal);
        end else begin
          e = q.pop_front();
          if ({bus.Operation, bus.SrcA, bus.SrcB, bus.out_illegal} !== {e.op, e.a, e.b, e.ill}) begin
            bad++;
            $display("FAIL sb_entry: got op=%h a=%h b=%h ill=%b, expected op=%h a=%h b=%h ill=%b",
                     bus.Operation, bus.SrcA, bus.SrcB, bus.out_illegal, e.op, e.a, e.b, e.ill);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(cur_exp);
        n_push++;
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] rs1,
                      input logic [31:0] rs2, input exp_t e);
    int unsigned start;
    int unsigned cyc;
    start = n_push;
    cyc   = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    cur_exp      = e;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (n_push == start && cyc < 50);
    total++;
    if (n_push == start) begin
      bad++;
      $display("FAIL send_timeout: instr=%h not accepted, got in_ready=%b, expected accept", instr, bus.in_ready);
    end else if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency: got out_valid=%b one cycle after accept, expected 1", bus.out_valid);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned cyc;
    cyc = 0;
    while ((q.size() != 0 || bus.out_valid) && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (q.size() != 0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain: got %0d pending, out_valid=%b, expected 0 pending, out_valid=0", q.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready, bus.out_illegal} !== 3'b010) begin
      bad++;
      $display("FAIL reset_flags: got out_valid=%b in_ready=%b ill=%b, expected 0 1 0",
               bus.out_valid, bus.in_ready, bus.out_illegal);
    end
    total++;
    if ({bus.SrcA, bus.SrcB, bus.Operation} !== 68'd0) begin
      bad++;
      $display("FAIL reset_data: got a=%h b=%h op=%h, expected zeros", bus.SrcA, bus.SrcB, bus.Operation);
    end
    total++;
    if (bus.illegal_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d, expected 0", bus.illegal_count);
    end
  endtask

  task automatic test_decode();
    bus.out_ready = 1'b1;
    send(32'h002081B3, 32'd5, 32'd7, mk(4'b0100, 32'd5, 32'd7, 1'b0));                        // add
    send(32'h40315093, 32'hFFFFFF00, 32'd9, mk(4'b0111, 32'hFFFFFF00, 32'd1027, 1'b0));       // srai
    send(32'h123452B7, 32'h55, 32'h66, mk(4'b1010, 32'd0, 32'h12345000, 1'b0));               // lui
    send(32'h0020D063, 32'd3, 32'hFFFFFFFF, mk(4'b0101, 32'd3, 32'hFFFFFFFF, 1'b0));          // bge
    send(32'h402081B3, 32'd20, 32'd3, mk(4'b0010, 32'd20, 32'd3, 1'b0));                      // sub
    send(32'hFFF10093, 32'd10, 32'd1, mk(4'b0100, 32'd10, 32'hFFFFFFFF, 1'b0));               // addi -1
    send(32'h0020A423, 32'h100, 32'h77, mk(4'b0100, 32'h100, 32'd8, 1'b0));                   // sw 8
    idle();
    drain();
    total++;
    if ({bus.Operation, bus.SrcA, bus.SrcB} !== {4'b0100, 32'h100, 32'd8}) begin
      bad++;
      $display("FAIL empty_hold: got op=%h a=%h b=%h, expected op=4 a=100 b=8",
               bus.Operation, bus.SrcA, bus.SrcB);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned start;
    int unsigned cyc;
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'd5, 32'd7, mk(4'b0100, 32'd5, 32'd7, 1'b0));
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready1: got in_ready=%b, expected 1", bus.in_ready);
    end
    send(32'h402081B3, 32'd20, 32'd3, mk(4'b0010, 32'd20, 32'd3, 1'b0));
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready2: got in_ready=%b, expected 0", bus.in_ready);
    end
    start = n_push;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0020C1B3;   // xor
    bus.in_rs1   = 32'h0000F0F0;
    bus.in_rs2   = 32'h00000FF0;
    cur_exp      = mk(4'b0001, 32'h0000F0F0, 32'h00000FF0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (n_push != start || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_hold: got %0d extra pushes, in_ready=%b, expected 0 and 0", n_push - start, bus.in_ready);
    end
    total++;
    if ({bus.out_valid, bus.Operation, bus.SrcA, bus.SrcB} !== {1'b1, 4'b0100, 32'd5, 32'd7}) begin
      bad++;
      $display("FAIL b2b_stable: got v=%b op=%h a=%h b=%h, expected v=1 op=4 a=5 b=7",
               bus.out_valid, bus.Operation, bus.SrcA, bus.SrcB);
    end
    bus.out_ready = 1'b1;
    cyc = 0;
    while (n_push == start && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (n_push == start) begin
      bad++;
      $display("FAIL b2b_third: got no accept of third, expected accept after pop");
    end
    idle();
    drain();
    total++;
    if (n_push != n_pop) begin
      bad++;
      $display("FAIL b2b_count: got pops=%0d, expected pushes=%0d", n_pop, n_push);
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    send(32'h0000007F, 32'd1, 32'd2, mk(4'b0000, 32'd0, 32'd0, 1'b1));
    idle();
    drain();
    total++;
    if (bus.illegal_count !== CNT_STEP) begin
      bad++;
      $display("FAIL illegal_count1: got %0d, expected %0d", bus.illegal_count, CNT_STEP);
    end
    send(32'h002091B3, 32'd4, 32'd5, mk(4'b0000, 32'd0, 32'd0, 1'b1));   // R funct3 001
    send(32'h022081B3, 32'd4, 32'd5, mk(4'b0000, 32'd0, 32'd0, 1'b1));   // add, bad funct7
    send(32'h0020A063, 32'd4, 32'd5, mk(4'b0000, 32'd0, 32'd0, 1'b1));   // branch funct3 010
    send(32'h0020F1B3, 32'd6, 32'd3, mk(4'b0000, 32'd6, 32'd3, 1'b0));   // and (legal)
    idle();
    drain();
    total++;
    if (bus.illegal_count !== 16'(CNT_STEP * 16'd4)) begin
      bad++;
      $display("FAIL illegal_count4: got %0d, expected %0d", bus.illegal_count, CNT_STEP * 16'd4);
    end
  endtask

  task automatic test_reset_flush();
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'd1, 32'd2, mk(4'b0100, 32'd1, 32'd2, 1'b0));
    send(32'h402081B3, 32'd3, 32'd4, mk(4'b0010, 32'd3, 32'd4, 1'b0));
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0020E1B3;   // or, dropped by reset
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL flush_flags: got out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
    total++;
    if ({bus.Operation, bus.SrcA, bus.SrcB, bus.illegal_count} !== 84'd0) begin
      bad++;
      $display("FAIL flush_data: got op=%h a=%h b=%h cnt=%0d, expected zeros",
               bus.Operation, bus.SrcA, bus.SrcB, bus.illegal_count);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_stale: got out_valid=%b, expected 0", bus.out_valid);
    end
    send(32'h0020E1B3, 32'h30, 32'h0C, mk(4'b0011, 32'h30, 32'h0C, 1'b0));
    idle();
    drain();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.out_ready = 1'b0;
    cur_exp       = mk(4'b0000, 32'd0, 32'd0, 1'b0);
    test_reset();
    test_decode();
    test_back_to_back();
    test_illegal();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
